// File: rtl/sram_rd_streamer_pkg.sv
// Shared constants and FSM encoding for the LSTM weight/state SRAM read path.
package lstm_mem_pkg;

    localparam int SRAM_DATA_W = 112;
    localparam int SRAM_ADDR_W = 8;
    localparam int LANE_W      = 14;
    localparam int N_LANES     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sram_rd_streamer_if.sv
// Valid/ready word stream from the SRAM read streamer to the MAC datapath.
interface sram_rd_streamer_if
    import lstm_mem_pkg::*;
#(
    parameter int DATA_W = SRAM_DATA_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/sram_rd_streamer_fifo.sv
// First-word-fall-through FIFO whose head word sits in a dedicated output register.
module stream_fifo #(
    parameter int WIDTH = 113,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr, r_rdPtr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_doPop, w_doPush;
    logic [AW-1:0]    w_rdPtrNext;
    logic [CW-1:0]    w_countAfterPop;
    logic [WIDTH-1:0] w_doutNext;

    assign w_doPop         = pop && (r_count != '0);
    assign w_doPush        = push && ((r_count != CW'(DEPTH)) || w_doPop);
    assign w_rdPtrNext     = r_rdPtr + AW'(w_doPop);
    assign w_countAfterPop = r_count - CW'(w_doPop);

    // The head register is preloaded with whatever will be at the front after this cycle.
    always_comb begin
        w_doutNext = r_dout;
        if (w_countAfterPop != '0)
            w_doutNext = r_mem[w_rdPtrNext];
        else if (w_doPush)
            w_doutNext = din;
    end

    always_ff @(posedge clk) begin
        if (w_doPush)
            r_mem[r_wrPtr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + AW'(w_doPush);
            r_rdPtr <= w_rdPtrNext;
            r_count <= w_countAfterPop + CW'(w_doPush);
            r_dout  <= w_doutNext;
        end
    end

    assign dout  = r_dout;
    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
endmodule

// File: rtl/sram_rd_streamer.sv
// Burst read engine: issues sequential SRAM reads under FIFO credit and streams the words out.
module sram_rd_streamer
    import lstm_mem_pkg::*;
#(
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              iStart,
    input  logic [ADDR_W-1:0] iBase_addr,
    input  logic [ADDR_W:0]   iLen,
    output logic              oBusy,
    output logic              oDone,
    output logic              oR_en,
    output logic [ADDR_W-1:0] oR_addr,
    input  logic [DATA_W-1:0] iD_in,
    output logic              oValid,
    input  logic              iReady,
    output logic [DATA_W-1:0] oData,
    output logic              oLast
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            r_state, w_stateNext;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_len, r_issueCnt;
    logic              r_inFlight, r_inFlightLast;

    logic              w_issue, w_lastIssue, w_pop, w_full, w_empty;
    logic [CW-1:0]     w_count;
    logic [CW:0]       w_credit;
    logic [DATA_W:0]   w_fifoOut;

    assign w_pop       = !w_empty && iReady;
    // Occupancy plus the outstanding read, as it will stand once this cycle's pop is taken.
    assign w_credit    = {1'b0, w_count} - (CW+1)'(w_pop) + (CW+1)'(r_inFlight);
    assign w_lastIssue = (r_issueCnt == r_len - 1'b1);

    always_comb begin
        w_stateNext = r_state;
        w_issue     = 1'b0;
        case (r_state)
            IDLE: begin
                if (iStart)
                    w_stateNext = (iLen != '0) ? ISSUE : DONE;
            end
            ISSUE: begin
                if (w_credit < (CW+1)'(FIFO_DEPTH)) begin
                    w_issue = 1'b1;
                    if (w_lastIssue)
                        w_stateNext = DRAIN;
                end
            end
            DRAIN: begin
                if (w_credit == '0)
                    w_stateNext = DONE;
            end
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= IDLE;
            r_addr         <= '0;
            r_len          <= '0;
            r_issueCnt     <= '0;
            r_inFlight     <= 1'b0;
            r_inFlightLast <= 1'b0;
        end else begin
            r_state        <= w_stateNext;
            r_inFlight     <= w_issue;
            r_inFlightLast <= w_issue && w_lastIssue;
            if (r_state == IDLE && iStart && iLen != '0) begin
                r_addr     <= iBase_addr;
                r_len      <= iLen;
                r_issueCnt <= '0;
            end else if (w_issue) begin
                r_addr     <= r_addr + 1'b1;
                r_issueCnt <= r_issueCnt + 1'b1;
            end
        end
    end

    stream_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (r_inFlight),
        .din   ({r_inFlightLast, iD_in}),
        .pop   (w_pop),
        .dout  (w_fifoOut),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    noOverflow: assert property (@(posedge clk) disable iff (!rstn)
        !(w_full && r_inFlight && !w_pop));

    assign oBusy   = (r_state != IDLE);
    assign oDone   = (r_state == DONE);
    assign oR_en   = !w_issue;
    assign oR_addr = r_addr;
    assign oValid  = !w_empty;
    assign oData   = w_fifoOut[DATA_W-1:0];
    assign oLast   = w_fifoOut[DATA_W] && !w_empty;
endmodule

// File: tb/tb_sram_rd_streamer.sv
// Bench for sram_rd_streamer: SRAM model, burst table with scoreboard, and hand-written corner cases.
module tb_sram_rd_streamer;
    import lstm_mem_pkg::*;

    localparam int DW = SRAM_DATA_W;
    localparam int AW = SRAM_ADDR_W;

    logic          clk = 1'b0;
    logic          rstn;
    logic          iStart;
    logic [AW-1:0] iBase_addr;
    logic [AW:0]   iLen;
    logic          oBusy, oDone, oR_en;
    logic [AW-1:0] oR_addr;
    logic [DW-1:0] iD_in;

    sram_rd_streamer_if #(.DATA_W(DW)) streamIf ();

    sram_rd_streamer dut (
        .clk        (clk),
        .rstn       (rstn),
        .iStart     (iStart),
        .iBase_addr (iBase_addr),
        .iLen       (iLen),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oR_en      (oR_en),
        .oR_addr    (oR_addr),
        .iD_in      (iD_in),
        .oValid     (streamIf.valid),
        .iReady     (streamIf.ready),
        .oData      (streamIf.data),
        .oLast      (streamIf.last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        logic [3:0] readyPat;
        logic       intrude;
        logic [7:0] expLastAddr;
    } vec_t;

    vec_t vecs[7];

    logic [DW-1:0] mem [256];
    logic [DW:0]   sbQ [$];
    logic          seen [256];

    int nCompared = 0;
    int nMismatch = 0;
    int ncyc = 0;
    int nIssued, nXfer, nValid, nDone;
    int doneCyc, lastXferCyc, outstanding;
    logic [7:0] curBase, lastAddr, expAddr;
    logic       prevStall, prevDone, prevLast, xferNow;
    logic [DW-1:0] prevData;
    logic [DW:0]   expEntry;

    function automatic logic [DW-1:0] expWord(input logic [7:0] a);
        return {N_LANES{6'b0, a}};
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous-read SRAM with one cycle of latency.
    always @(posedge clk) begin
        if (!oR_en)
            iD_in <= mem[oR_addr];
    end

    // Monitor: address order, credit, stall stability, scoreboard and done/busy timing.
    always @(negedge clk) begin
        if (!rstn) begin
            prevStall = 1'b0;
            prevDone  = 1'b0;
        end else begin
            ncyc++;
            xferNow = streamIf.valid && streamIf.ready;
            if (prevStall) begin
                checkOutput("stallValid", 128'(streamIf.valid), 1);
                checkOutput("stallData", 128'(streamIf.data), 128'(prevData));
                checkOutput("stallLast", 128'(streamIf.last), 128'(prevLast));
            end
            if (prevDone)
                checkOutput("busyAfterDone", 128'(oBusy), 0);
            if (!oR_en) begin
                outstanding = nIssued - nXfer - (xferNow ? 1 : 0);
                checkOutput("credit", 128'(outstanding < 4), 1);
                expAddr = curBase + 8'(nIssued);
                checkOutput("rdAddr", 128'(oR_addr), 128'(expAddr));
                checkOutput("addrRepeat", 128'(seen[oR_addr]), 0);
                seen[oR_addr] = 1'b1;
                lastAddr = oR_addr;
                nIssued++;
            end
            if (streamIf.valid)
                nValid++;
            if (xferNow) begin
                if (sbQ.size() == 0) begin
                    checkOutput("xferExtra", 128'(sbQ.size()), 1);
                end else begin
                    expEntry = sbQ.pop_front();
                    checkOutput("data", 128'(streamIf.data), 128'(expEntry[DW-1:0]));
                    checkOutput("last", 128'(streamIf.last), 128'(expEntry[DW]));
                end
                nXfer++;
                lastXferCyc = ncyc;
            end
            if (oDone) begin
                nDone++;
                doneCyc = ncyc;
                checkOutput("busyWithDone", 128'(oBusy), 1);
            end
            prevDone  = oDone;
            prevStall = streamIf.valid && !streamIf.ready;
            prevData  = streamIf.data;
            prevLast  = streamIf.last;
        end
    end

    task automatic clearStats(input logic [7:0] base);
        nIssued = 0;
        nXfer   = 0;
        nValid  = 0;
        nDone   = 0;
        doneCyc = -100;
        lastXferCyc = -200;
        curBase = base;
        sbQ.delete();
        for (int i = 0; i < 256; i++)
            seen[i] = 1'b0;
    endtask

    task automatic pushExpected(input logic [7:0] base, input logic [8:0] len);
        logic [7:0] a;
        for (int k = 0; k < int'(len); k++) begin
            a = base + 8'(k);
            sbQ.push_back({(k == int'(len) - 1), expWord(a)});
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        bit finished = 0;
        clearStats(v.base);
        pushExpected(v.base, v.len);
        @(posedge clk); #1;
        iStart = 1'b1;
        iBase_addr = v.base;
        iLen = v.len;
        streamIf.ready = v.readyPat[0];
        for (int c = 1; c < 3000; c++) begin
            @(posedge clk); #1;
            iStart = v.intrude && (c == 3);
            iBase_addr = 8'h90;
            iLen = 9'd3;
            streamIf.ready = v.readyPat[c % 4];
            if (nDone > 0 && !oBusy) begin
                finished = 1;
                break;
            end
        end
        checkOutput($sformatf("burstTimeout[%0d]", idx), 128'(finished), 1);
        checkOutput($sformatf("nIssued[%0d]", idx), 128'(nIssued), 128'(v.len));
        checkOutput($sformatf("nXfer[%0d]", idx), 128'(nXfer), 128'(v.len));
        checkOutput($sformatf("lastAddr[%0d]", idx), 128'(lastAddr), 128'(v.expLastAddr));
        checkOutput($sformatf("sbDrained[%0d]", idx), 128'(sbQ.size()), 0);
        checkOutput($sformatf("nDone[%0d]", idx), 128'(nDone), 1);
        checkOutput($sformatf("doneLatency[%0d]", idx), 128'(doneCyc - lastXferCyc), 1);
        streamIf.ready = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Busy"}, 128'(oBusy), 0);
        checkOutput({tag, "Done"}, 128'(oDone), 0);
        checkOutput({tag, "REn"}, 128'(oR_en), 1);
        checkOutput({tag, "RAddr"}, 128'(oR_addr), 0);
        checkOutput({tag, "Valid"}, 128'(streamIf.valid), 0);
        checkOutput({tag, "Data"}, 128'(streamIf.data), 0);
        checkOutput({tag, "Last"}, 128'(streamIf.last), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit finished;
        int startCyc;
        for (int i = 0; i < 256; i++)
            mem[i] = {N_LANES{14'(i)}};

        vecs[0] = '{base: 8'h10, len: 9'd8,   readyPat: 4'b1111, intrude: 1'b0, expLastAddr: 8'h17};
        vecs[1] = '{base: 8'hFE, len: 9'd4,   readyPat: 4'b1111, intrude: 1'b0, expLastAddr: 8'h01};
        vecs[2] = '{base: 8'h40, len: 9'd16,  readyPat: 4'b1001, intrude: 1'b0, expLastAddr: 8'h4F};
        vecs[3] = '{base: 8'h00, len: 9'd256, readyPat: 4'b1111, intrude: 1'b0, expLastAddr: 8'hFF};
        vecs[4] = '{base: 8'h20, len: 9'd8,   readyPat: 4'b1111, intrude: 1'b1, expLastAddr: 8'h27};
        vecs[5] = '{base: 8'h80, len: 9'd1,   readyPat: 4'b0110, intrude: 1'b0, expLastAddr: 8'h80};
        vecs[6] = '{base: 8'hF0, len: 9'd20,  readyPat: 4'b0101, intrude: 1'b0, expLastAddr: 8'h03};

        rstn = 1'b0;
        iStart = 1'b0;
        iBase_addr = '0;
        iLen = '0;
        streamIf.ready = 1'b0;
        clearStats(8'h00);
        #12;
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        for (int i = 0; i < 7; i++)
            applyStimulus(vecs[i], i);

        // Empty burst: a done pulse the cycle after the command, no reads, no stream words.
        clearStats(8'h33);
        @(posedge clk); #1;
        iStart = 1'b1;
        iBase_addr = 8'h33;
        iLen = 9'd0;
        @(negedge clk); #1;
        startCyc = ncyc;
        @(posedge clk); #1;
        iStart = 1'b0;
        finished = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (nDone > 0 && !oBusy) begin
                finished = 1;
                break;
            end
        end
        checkOutput("emptyTimeout", 128'(finished), 1);
        checkOutput("emptyIssued", 128'(nIssued), 0);
        checkOutput("emptyValid", 128'(nValid), 0);
        checkOutput("emptyDone", 128'(nDone), 1);
        checkOutput("emptyDoneCyc", 128'(doneCyc - startCyc), 1);

        // Reset while word 3 of an 8-word burst is stalled at the output.
        clearStats(8'h50);
        pushExpected(8'h50, 9'd8);
        @(posedge clk); #1;
        iStart = 1'b1;
        iBase_addr = 8'h50;
        iLen = 9'd8;
        streamIf.ready = 1'b1;
        finished = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            iStart = 1'b0;
            if (nXfer >= 3) begin
                streamIf.ready = 1'b0;
                finished = 1;
                break;
            end
        end
        checkOutput("abortReachWord3", 128'(finished), 1);
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        checkResetOutputs("abort");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        sbQ.delete();
        nDone = 0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("abortNoDone", 128'(nDone), 0);
        checkOutput("abortIdle", 128'(oBusy), 0);

        applyStimulus('{base: 8'h60, len: 9'd8, readyPat: 4'b1101, intrude: 1'b0, expLastAddr: 8'h67}, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end
endmodule
